dmem_arbiter: RTL

// - Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/loader).
// - One access per clock. Conflicts resolve round-robin. A requester can lock the memory for atomic read-modify-write sequences.
// - Sits between the requesters and the data memory. It drives the memory WE/addr/WD pins and returns registered read data.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_rr_pick2.sv | 27 ++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and the data memory itself.
//   - NUM_PORTS  : number of requesters sharing the memory
//   - DMEM_WIDTH : data word width, matches the data memory
//   - DMEM_DEPTH : address width in words, matches the data memory
//   - state_e    : arbiter FSM states (free arbitration / held by port 0 / 1)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DMEM_WIDTH = 32;
    localparam int DMEM_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req_i[1:0]   in   request per port
//   last_i       in   port that received the most recent grant
//   grant_o[1:0] out  one-hot grant (all zero when nobody requests)
// On a tie the port that was NOT granted last wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path infers a latch.
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the CPU (port 0) and the
// debug/loader port (port 1). One access per clock, round-robin on conflict,
// and a lock that lets the current owner run an atomic read-modify-write.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   req0/1, we0/1          request (held until gnt), 1 = write / 0 = read
//   addr0/1, wd0/1         word address and write data
//   lock0/1                keep ownership after this access
//   gnt0/1                 combinational grant, access happens this cycle
//   rvalid0/1, rdata0/1    read response, one cycle after a granted read
//   mem_we/addr/wd         memory-side controls of the granted port (else 0)
//   mem_rd                 memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH = DMEM_WIDTH,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wd0,
    input  logic [WIDTH-1:0] wd1,
    input  logic             lock0,
    input  logic             lock1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_we,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    state_e                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [NUM_PORTS-1:0]  pick;
    logic [NUM_PORTS-1:0]  gnt;
    logic                  rd_take0, rd_take1;
    logic                  rvalid0_q, rvalid1_q;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d;
    logic [WIDTH-1:0]      rdata1_q, rdata1_d;

    rr_pick2 u_pick (
        .req_i   ({req1, req0}),
        .last_i  (rr_last_q),
        .grant_o (pick)
    );

    // Next state and grant.
    always_comb begin
        state_d = state_q;
        gnt     = 2'b00;
        case (state_q)
            IDLE: begin
                gnt = pick;
                if (gnt[0] && lock0) begin
                    state_d = LOCK0;
                end else if (gnt[1] && lock1) begin
                    state_d = LOCK1;
                end
            end
            // The owner is still served in the cycle it releases the lock;
            // arbitration resumes from the next cycle.
            LOCK0: begin
                gnt = {1'b0, req0};
                if (!req0 || !lock0) begin
                    state_d = IDLE;
                end
            end
            LOCK1: begin
                gnt = {req1, 1'b0};
                if (!req1 || !lock1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The grant is combinational from req, so it must be gated by the
        // reset itself to drop the instant reset_n falls.
        if (!reset_n) begin
            gnt = 2'b00;
        end

        rr_last_d = rr_last_q;
        if (gnt[0]) begin
            rr_last_d = 1'b0;
        end else if (gnt[1]) begin
            rr_last_d = 1'b1;
        end
    end

    // Memory-side mux: idle cycles drive all zeros.
    always_comb begin
        mem_we   = (gnt[0] & we0) | (gnt[1] & we1);
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt[0]) begin
            mem_addr = addr0;
            mem_wd   = wd0;
        end else if (gnt[1]) begin
            mem_addr = addr1;
            mem_wd   = wd1;
        end
    end

    assign rd_take0 = gnt[0] & ~we0;
    assign rd_take1 = gnt[1] & ~we1;
    assign rdata0_d = rd_take0 ? mem_rd : rdata0_q;
    assign rdata1_d = rd_take1 ? mem_rd : rdata1_q;

    // rr_last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            rvalid0_q <= rd_take0;
            rvalid1_q <= rd_take1;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule : dmem_arbiter
